// File: rtl/param_sync_fifo_if.sv
// Handshake/bus bundle for param_sync_fifo: write side, read side, status flags and occupancy.
// Ports: wr_en/data_in/rd_en driven by the user (master), data_out/data_valid/flags/count driven by the FIFO (slave).
// With PARAM_SYNC_FIFO_ERR_FLAGS_EN defined the bundle also carries err_clr, overflow and underflow.
interface param_sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    logic                  err_clr;
    logic                  overflow;
    logic                  underflow;
`endif

    modport master (
        output wr_en, data_in, rd_en,
        input  data_out, data_valid, full, empty, almost_full, almost_empty, count
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
        , output err_clr, input overflow, underflow
`endif
    );

    modport slave (
        input  wr_en, data_in, rd_en,
        output data_out, data_valid, full, empty, almost_full, almost_empty, count
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
        , input err_clr, output overflow, underflow
`endif
    );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO, any depth >= 2, programmable almost-full/almost-empty watermarks, standard or FWFT read.
// Latency: standard mode data_out 1 cycle after accepted read; FWFT mode head word visible 1 cycle after write.
// Backpressure: writes ignored while full, reads ignored while empty. Optional macro PARAM_SYNC_FIFO_ERR_FLAGS_EN
// adds sticky overflow/underflow flags with synchronous err_clr.
// Ports: clk, reset (async active-high), bus (param_sync_fifo_if.slave).
module param_sync_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 8,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    param_sync_fifo_if.slave     bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Elaboration-time parameter checks
    if (DATA_WIDTH < 1) begin : g_bad_width
        $fatal(1, "param_sync_fifo: DATA_WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "param_sync_fifo: DEPTH must be >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $fatal(1, "param_sync_fifo: AFULL_THRESH out of range 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $fatal(1, "param_sync_fifo: AEMPTY_THRESH out of range 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  is_full;
    logic                  is_empty;
    logic                  wr_acc;
    logic                  rd_acc;

    // Non-power-of-2 depth: wrap explicitly at DEPTH-1
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    // Accept decisions use registered flags only, so no write-through when full or read-through when empty
    assign wr_acc   = bus.wr_en && !is_full;
    assign rd_acc   = bus.rd_en && !is_empty;

    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = (count_q >= CW'(AFULL_THRESH));
    assign bus.almost_empty = (count_q <= CW'(AEMPTY_THRESH));
    assign bus.count        = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            count_q <= count_q + CW'(wr_acc) - CW'(rd_acc);
        end
    end

    // Storage is deliberately not reset; the occupancy counter makes stale words unreachable
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.data_in;
    end

    if (FWFT == 0) begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  dv_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dout_q <= '0;
                dv_q   <= 1'b0;
            end else begin
                dv_q <= rd_acc;
                if (rd_acc) dout_q <= mem[rd_ptr];
            end
        end

        assign bus.data_out   = dout_q;
        assign bus.data_valid = dv_q;
    end else begin : g_fwft
        // Head word is presented combinationally; rd_en acts as a pop
        assign bus.data_out   = is_empty ? '0 : mem[rd_ptr];
        assign bus.data_valid = !is_empty;
    end

`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic udf_q;

    // Setting takes priority over a clear in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.wr_en && is_full) ovf_q <= 1'b1;
            else if (bus.err_clr)     ovf_q <= 1'b0;
            if (bus.rd_en && is_empty) udf_q <= 1'b1;
            else if (bus.err_clr)      udf_q <= 1'b0;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
`endif
endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;
    localparam int DW = 8;
    localparam int DP = 5;
    localparam int AF = 4;
    localparam int AE = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) if0 ();
    param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) if1 ();

    param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .FWFT(0))
        u_std (.clk(clk), .reset(reset), .bus(if0.slave));
    param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .FWFT(1))
        u_fwft (.clk(clk), .reset(reset), .bus(if1.slave));

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a queue of stored words plus the expected standard-mode read register
    logic [7:0] q[$];
    logic [7:0] e_dout0;
    logic       e_dv0;
    logic       e_ovf;
    logic       e_udf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        logic [7:0] head;
        n = q.size();
        head = (n > 0) ? q[0] : 8'h00;
        chk("std.count",        32'(if0.count),        32'(n));
        chk("std.full",         32'(if0.full),         32'(n == DP));
        chk("std.empty",        32'(if0.empty),        32'(n == 0));
        chk("std.almost_full",  32'(if0.almost_full),  32'(n >= AF));
        chk("std.almost_empty", 32'(if0.almost_empty), 32'(n <= AE));
        chk("std.data_out",     32'(if0.data_out),     32'(e_dout0));
        chk("std.data_valid",   32'(if0.data_valid),   32'(e_dv0));
        chk("fwft.count",       32'(if1.count),        32'(n));
        chk("fwft.empty",       32'(if1.empty),        32'(n == 0));
        chk("fwft.data_out",    32'(if1.data_out),     32'(head));
        chk("fwft.data_valid",  32'(if1.data_valid),   32'(n > 0));
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
        chk("std.overflow",     32'(if0.overflow),     32'(e_ovf));
        chk("std.underflow",    32'(if0.underflow),    32'(e_udf));
        chk("fwft.overflow",    32'(if1.overflow),     32'(e_ovf));
        chk("fwft.underflow",   32'(if1.underflow),    32'(e_udf));
`endif
    endtask

    task automatic drive(input logic we, input logic [7:0] din, input logic re, input logic clr);
        if0.wr_en = we; if0.data_in = din; if0.rd_en = re;
        if1.wr_en = we; if1.data_in = din; if1.rd_en = re;
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
        if0.err_clr = clr; if1.err_clr = clr;
`else
        if (clr) begin end
`endif
    endtask

    // One clock: apply inputs, advance model at the edge, compare 1 time unit later
    task automatic cycle(input logic we, input logic [7:0] din, input logic re, input logic clr);
        bit full_b, empty_b, wa, ra;
        drive(we, din, re, clr);
        @(posedge clk);
        full_b  = (q.size() == DP);
        empty_b = (q.size() == 0);
        wa = we && !full_b;
        ra = re && !empty_b;
        e_dv0 = ra;
        if (ra) e_dout0 = q.pop_front();
        if (wa) q.push_back(din);
        if (we && full_b) e_ovf = 1'b1; else if (clr) e_ovf = 1'b0;
        if (re && empty_b) e_udf = 1'b1; else if (clr) e_udf = 1'b0;
        #1;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        e_dout0 = 8'h00; e_dv0 = 1'b0; e_ovf = 1'b0; e_udf = 1'b0;
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        model_reset();
        // Reset state
        #1;
        check_all();
        @(posedge clk); #1;
        reset = 1'b0;
        check_all();

        // 1: fill, overflow attempt, drain in order
        for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(8'h11 * i), 1'b0, 1'b0);
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);           // clear overflow
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // 2: pointer wrap with non-power-of-2 depth
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // 3: simultaneous write/read at count 2, empty and full
        cycle(1'b1, 8'h31, 1'b0, 1'b0);
        cycle(1'b1, 8'h32, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);           // empty: write only
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // 4: watermarks stepping 0..5
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0);           // full: read only
        cycle(1'b1, 8'hEF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // 5: FWFT fall-through of a single word
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
        while (q.size() != 3) begin
            if (q.size() < 3) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
            else              cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // 6: asynchronous reset mid-stream at count 3
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk); #1;
        reset = 1'b0;
        check_all();
        cycle(1'b1, 8'h7E, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);           // read on empty
        cycle(1'b0, 8'h00, 1'b1, 1'b1);           // set wins over clear
        cycle(1'b0, 8'h00, 1'b0, 1'b1);           // clear underflow
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
